// File: rtl/ld16_seq_if.sv
// Memory read port and register-file port of the 16-bit load sequencer.
// Handshake: mem_re is a request held until mem_rdy; a byte transfers in a cycle where both are high.
interface ld16_seq_if;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_rdy;
  logic [7:0]  mem_data;
  logic [15:0] regfile_data_out;
  logic [4:0]  regfile_rn_out;
  logic [4:0]  regfile_rn_in;
  logic [7:0]  regfile_data_in;
  logic        regfile_we;
  logic        regfile_change16;
  logic        regfile_inc;

  modport master (
    output mem_addr, mem_re, regfile_rn_out, regfile_rn_in, regfile_data_in,
           regfile_we, regfile_change16, regfile_inc,
    input  mem_rdy, mem_data, regfile_data_out
  );

  modport slave (
    input  mem_addr, mem_re, regfile_rn_out, regfile_rn_in, regfile_data_in,
           regfile_we, regfile_change16, regfile_inc,
    output mem_rdy, mem_data, regfile_data_out
  );
endinterface

// File: rtl/ld16_seq.sv
// Loads a 16-bit register from memory through PC or SP, low byte first, advancing the pointer by 2.
// Optional read timeout compiled in with LD16_TIMEOUT_EN.
module ld16_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [2:0] dest,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] fsm_state,
  ld16_seq_if.master bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    WR_LO  = 3'd2,
    INC_LO = 3'd3,
    RD_HI  = 3'd4,
    WR_HI  = 3'd5,
    INC_HI = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t      state, state_nx;
  logic        mode_q;
  logic [1:0]  dest_q;
  logic [7:0]  data_q;
  logic [2:0]  ptr_in, ptr_q;
  logic        start_legal, in_read, timeout;
  logic        mem_re_c, we_c, change16_c;
  logic [15:0] mem_addr_c;
  logic [4:0]  rn_in_c;
  logic [7:0]  data_in_c;

  assign ptr_in      = mode ? 3'd3 : 3'd4;
  assign ptr_q       = mode_q ? 3'd3 : 3'd4;
  assign start_legal = (dest <= 3'd3) && (dest != ptr_in);
  assign in_read     = (state == RD_LO) || (state == RD_HI);

`ifdef LD16_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Counts idle read cycles; leaving a read state clears it, so each read starts from zero.
  always_ff @(posedge clock) begin
    if (reset || !in_read) wait_cnt <= 4'd0;
    else if (!bus.mem_rdy) wait_cnt <= wait_cnt + 4'd1;
  end

  assign timeout = in_read && !bus.mem_rdy && (wait_cnt == 4'hF);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      dest_q <= 2'd0;
      data_q <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && start_legal) begin
        mode_q <= mode;
        dest_q <= dest[1:0];
      end
      if (mem_re_c && bus.mem_rdy) data_q <= bus.mem_data;
    end
  end

  always_comb begin
    state_nx   = state;
    mem_re_c   = 1'b0;
    mem_addr_c = 16'h0000;
    we_c       = 1'b0;
    change16_c = 1'b0;
    rn_in_c    = 5'd0;
    data_in_c  = 8'h00;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_legal) state_nx = RD_LO;
          else             err      = 1'b1;
        end
      end
      RD_LO, RD_HI: begin
        mem_re_c   = 1'b1;
        mem_addr_c = bus.regfile_data_out;
        if (bus.mem_rdy) begin
          state_nx = (state == RD_LO) ? WR_LO : WR_HI;
        end else if (timeout) begin
          err      = 1'b1;
          state_nx = IDLE;
        end
      end
      WR_LO, WR_HI: begin
        we_c      = 1'b1;
        rn_in_c   = {1'b0, (state == WR_HI), 1'b0, dest_q};
        data_in_c = data_q;
        state_nx  = (state == WR_LO) ? INC_LO : INC_HI;
      end
      INC_LO, INC_HI: begin
        we_c       = 1'b1;
        change16_c = 1'b1;
        rn_in_c    = {2'b10, ptr_q};
        state_nx   = (state == INC_LO) ? RD_HI : DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Writes are masked while reset is high so an abort never commits the in-flight write.
  assign bus.regfile_we       = we_c & ~reset;
  assign bus.regfile_change16 = change16_c & ~reset;
  assign bus.regfile_rn_in    = rn_in_c;
  assign bus.regfile_data_in  = data_in_c;
  assign bus.regfile_inc      = 1'b1;
  assign bus.regfile_rn_out   = {2'b10, ptr_q};
  assign bus.mem_re           = mem_re_c;
  assign bus.mem_addr         = mem_addr_c;
  assign busy                 = (state != IDLE);
  assign fsm_state            = state;
endmodule

// File: tb/tb_ld16_seq.sv
// Bench for ld16_seq: register-file and memory models, vector table, and reset/stall/timeout sequences.
module tb_ld16_seq;
  logic       clock = 1'b0;
  logic       reset, start, mode;
  logic [2:0] dest;
  logic       busy, done, err;
  logic [2:0] fsm_state;

  ld16_seq_if bus();

  ld16_seq dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .dest(dest),
    .busy(busy), .done(done), .err(err), .fsm_state(fsm_state), .bus(bus)
  );

  always #5 clock = ~clock;

  // memory and register-file models
  logic [7:0]  mem [0:65535];
  logic [15:0] rf  [0:7];
  logic        rdy_off = 1'b0, pre_en = 1'b0, clr = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [15:0] pre_val = 16'h0;
  int          wr_count = 0, stall_used = 0, stall_cfg = 0;
  logic        hi_phase;

  assign hi_phase          = (wr_count == 2);
  assign bus.mem_data      = mem[bus.mem_addr];
  assign bus.mem_rdy       = !rdy_off && !(hi_phase && stall_used < stall_cfg);
  assign bus.regfile_data_out = rf[bus.regfile_rn_out[2:0]];

  always @(posedge clock) begin
    if (pre_en) rf[pre_idx] <= pre_val;
    if (clr) begin
      wr_count   <= 0;
      stall_used <= 0;
    end else begin
      if (bus.regfile_we) begin
        wr_count <= wr_count + 1;
        if (bus.regfile_rn_in[4] && bus.regfile_change16)
          rf[bus.regfile_rn_in[2:0]] <= rf[bus.regfile_rn_in[2:0]] + 16'd1;
        else if (bus.regfile_rn_in[3])
          rf[bus.regfile_rn_in[2:0]][15:8] <= bus.regfile_data_in;
        else
          rf[bus.regfile_rn_in[2:0]][7:0] <= bus.regfile_data_in;
      end
      if (bus.mem_re && hi_phase && stall_used < stall_cfg) stall_used <= stall_used + 1;
    end
  end

  typedef struct {
    logic        m;
    logic [2:0]  d;
    logic [15:0] p;
    logic [7:0]  lo, hi;
    int          stall;
    logic        exp_err;
    logic [15:0] exp_d, exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:11];
  vec_t exp_q [$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] v);
    pre_idx = idx; pre_val = v; pre_en = 1'b1;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic prepare(input logic m, input logic [2:0] d, input logic [15:0] p,
                         input logic [7:0] lo, input logic [7:0] hi, input int stall);
    logic [15:0] p1;
    p1 = p + 16'd1;
    set_reg(m ? 3'd3 : 3'd4, p);
    if (d <= 3'd3) set_reg(d, 16'h5A5A);
    mem[p] = lo; mem[p1] = hi;
    stall_cfg = stall;
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   k;
    logic saw_err, addr_moved, have_prev;
    logic [15:0] prev_addr;
    prepare(v.m, v.d, v.p, v.lo, v.hi, v.stall);
    start = 1'b1; mode = v.m; dest = v.d;
    exp_q.push_back(v);
    #1;
    if (v.exp_err) begin
      e = exp_q.pop_front();
      chk("err_pulse", {31'd0, err}, {31'd0, e.exp_err});
      @(negedge clock);
      start = 1'b0;
      #1;
      chk("err_one_cycle", {31'd0, err}, 32'd0);
      chk("err_busy_low", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clock);
      chk("err_no_write", wr_count, 32'd0);
      return;
    end
    chk("start_no_err", {31'd0, err}, 32'd0);
    @(negedge clock);
    k = 1; saw_err = 1'b0; addr_moved = 1'b0; have_prev = 1'b0; prev_addr = 16'h0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("inc_const", {31'd0, bus.regfile_inc}, 32'd1);
    while (done !== 1'b1 && k < 40) begin
      // an illegal start while busy must be ignored without err
      if (k == 3) begin start = 1'b1; dest = 3'd5; end
      else start = 1'b0;
      #1;
      if (err) saw_err = 1'b1;
      if (bus.mem_re && !bus.mem_rdy) begin
        if (have_prev && bus.mem_addr != prev_addr) addr_moved = 1'b1;
        prev_addr = bus.mem_addr; have_prev = 1'b1;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("done_latency", k, e.exp_lat);
    chk("no_err_while_busy", {31'd0, saw_err}, 32'd0);
    chk("addr_stable_stall", {31'd0, addr_moved}, 32'd0);
    chk("dest_value", {16'd0, rf[e.d]}, {16'd0, e.exp_d});
    chk("ptr_value", {16'd0, rf[e.m ? 3 : 4]}, {16'd0, e.exp_p});
    chk("write_count", wr_count, 32'd4);
    @(negedge clock);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    logic [15:0] rp;
    reset = 1'b1; start = 1'b0; mode = 1'b0; dest = 3'd0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    vecs[0] = '{1'b0, 3'd1, 16'h0150, 8'h34, 8'h12, 0, 1'b0, 16'h1234, 16'h0152, 7};
    vecs[1] = '{1'b1, 3'd2, 16'hFFFF, 8'hCD, 8'hAB, 0, 1'b0, 16'hABCD, 16'h0001, 7};
    vecs[2] = '{1'b1, 3'd3, 16'h4000, 8'h00, 8'h00, 0, 1'b1, 16'h0000, 16'h0000, 0};
    vecs[3] = '{1'b1, 3'd5, 16'h4000, 8'h00, 8'h00, 0, 1'b1, 16'h0000, 16'h0000, 0};
    vecs[4] = '{1'b0, 3'd4, 16'h4000, 8'h00, 8'h00, 0, 1'b1, 16'h0000, 16'h0000, 0};
    vecs[5] = '{1'b0, 3'd3, 16'h1000, 8'h78, 8'h56, 0, 1'b0, 16'h5678, 16'h1002, 7};
    vecs[6] = '{1'b1, 3'd0, 16'h2000, 8'h9A, 8'hBC, 5, 1'b0, 16'hBC9A, 16'h2002, 12};
    vecs[7] = '{1'b0, 3'd2, 16'hFFFF, 8'h01, 8'h80, 0, 1'b0, 16'h8001, 16'h0001, 7};
    for (int i = 8; i < 12; i++) begin
      vecs[i].m     = $urandom_range(0, 1);
      vecs[i].d     = vecs[i].m ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 3));
      vecs[i].p     = 16'($urandom_range(0, 65535));
      vecs[i].lo    = 8'($urandom_range(0, 255));
      vecs[i].hi    = 8'($urandom_range(0, 255));
      vecs[i].stall = $urandom_range(0, 3);
      vecs[i].exp_err = 1'b0;
      vecs[i].exp_d   = {vecs[i].hi, vecs[i].lo};
      vecs[i].exp_p   = vecs[i].p + 16'd2;
      vecs[i].exp_lat = 7 + vecs[i].stall;
    end

    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_we", {31'd0, bus.regfile_we}, 32'd0);
    chk("rst_change16", {31'd0, bus.regfile_change16}, 32'd0);
    chk("rst_rn_in", {27'd0, bus.regfile_rn_in}, 32'd0);
    chk("rst_data_in", {24'd0, bus.regfile_data_in}, 32'd0);
    chk("rst_state", {29'd0, fsm_state}, 32'd0);
    @(negedge clock);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // reset during WR_HI: only the low byte reaches the destination
    prepare(1'b0, 3'd1, 16'h0300, 8'h11, 8'h22, 0);
    start = 1'b1; mode = 1'b0; dest = 3'd1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_state_wr_hi", {29'd0, fsm_state}, 32'd5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_state", {29'd0, fsm_state}, 32'd0);
    chk("abort_we", {31'd0, bus.regfile_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dest", {16'd0, rf[1]}, 32'h5A11);
    chk("abort_writes", wr_count, 32'd2);
    chk("abort_ptr", {16'd0, rf[4]}, 32'h0301);
    @(negedge clock);

    // memory never ready
    prepare(1'b0, 3'd0, 16'h0500, 8'h00, 8'h00, 0);
    rdy_off = 1'b1;
    start = 1'b1; mode = 1'b0; dest = 3'd0;
    @(negedge clock);
    start = 1'b0;
`ifdef LD16_TIMEOUT_EN
    k = 1;
    while (err !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("timeout_cycle", k, 32'd16);
    @(negedge clock);
    chk("timeout_busy_low", {31'd0, busy}, 32'd0);
    chk("timeout_no_write", wr_count, 32'd0);
`else
    k = 0;
    repeat (30) begin
      @(negedge clock);
      if (err) k++;
    end
    chk("wait_busy_high", {31'd0, busy}, 32'd1);
    chk("wait_mem_re", {31'd0, bus.mem_re}, 32'd1);
    chk("wait_no_err", k, 32'd0);
    chk("wait_no_write", wr_count, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`endif
    rdy_off = 1'b0;
    @(negedge clock);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ld16_seq.md
LD16_SEQ -- requirements
Module: ld16_seq

Interface
REQ-001 clock  input  1  single system clock; all state updates on posedge clock.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-003 start  input  1  one-cycle request to load a 16-bit register from memory; sampled only in IDLE.
REQ-004 mode  input  1  pointer select: 0 = PC (immediate operand, index 4); 1 = SP (pop, index 3).
REQ-005 dest  input  3  destination register index: 0 BC, 1 DE, 2 HL, 3 SP; captured with start.
REQ-006 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-007 done  output  1  one-cycle pulse in DONE.
REQ-008 err  output  1  one-cycle pulse on a rejected start, or on a timeout when the timeout feature is compiled in.
REQ-009 mem_addr  output  16  read address; equals regfile_data_out while in a read state, else 16'h0000.
REQ-010 mem_re  output  1  read strobe; high in RD_LO and RD_HI.
REQ-011 mem_rdy  input  1  read data valid this cycle.
REQ-012 mem_data  input  8  read data; captured when mem_re and mem_rdy are both high.
REQ-013 regfile_data_out  input  16  full pointer value from the register file.
REQ-014 regfile_rn_out  output  5  fixed to {1'b1, 1'b0, ptr}, where ptr is 3'd4 (mode 0) or 3'd3 (mode 1).
REQ-015 regfile_rn_in  output  5  register-file write select, in FHRRR form.
REQ-016 regfile_data_in  output  8  byte to write.
REQ-017 regfile_we  output  1  register-file write enable.
REQ-018 regfile_change16  output  1  requests a 16-bit increment or decrement of the selected full register.
REQ-019 regfile_inc  output  1  1 = increment; always 1 from this block.

Function
REQ-020 The block SHALL implement the states IDLE, RD_LO, WR_LO, INC_LO, RD_HI, WR_HI, INC_HI and DONE.
REQ-021 IDLE: start with a legal dest SHALL latch mode and dest and move to RD_LO.
- Legal dest: dest <= 3 and dest != ptr.
REQ-022 IDLE: start with dest > 3, or dest == ptr, SHALL pulse err for 1 cycle, stay in IDLE, and cause no register write.
REQ-023 RD_LO / RD_HI SHALL hold mem_re high until mem_rdy.
- On mem_rdy: capture mem_data into data_q and advance to WR_LO / WR_HI in the same cycle.
REQ-024 WR_LO SHALL drive regfile_we=1, regfile_rn_in={0,0,dest}, regfile_data_in=data_q, then go to INC_LO.
REQ-025 WR_HI SHALL be identical to WR_LO except regfile_rn_in={0,1,dest}, then go to INC_HI.
REQ-026 INC_LO / INC_HI SHALL drive regfile_we=1, regfile_rn_in={1,0,ptr}, regfile_change16=1, regfile_inc=1.
- Next state: RD_HI / DONE respectively.
REQ-027 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-028 Latency with mem_rdy already high: start at cycle N gives done at cycle N+7, with exactly 4 register-file writes.
REQ-029 The low byte SHALL be read first (little-endian); the pointer SHALL advance by exactly 2 per completed operation.
REQ-030 Pointer 16'hFFFF SHALL wrap to 16'h0000 between the low and high reads; the high byte is read from 16'h0000.
REQ-031 start while busy SHALL be ignored, with no err.
REQ-032 Outside WR_* and INC_* states, regfile_we, regfile_change16 and regfile_rn_in SHALL be 0; regfile_inc SHALL be constant 1.

Reset
REQ-033 reset SHALL force IDLE, and the following SHALL read 0 on the cycle after reset is sampled: busy, done, err, mem_re, mem_addr, regfile_we, regfile_change16, regfile_rn_in, regfile_data_in, data_q.
REQ-034 reset asserted mid-operation SHALL abort with no further register-file writes; writes already issued are not undone.

Configuration
REQ-035 With LD16_TIMEOUT_EN defined, a 4-bit counter SHALL count RD_LO/RD_HI cycles without mem_rdy.
- At the 16th such cycle: pulse err, go to IDLE, no further writes.
- The counter clears on entry to each read state.
REQ-036 Without LD16_TIMEOUT_EN, read states SHALL wait indefinitely and err SHALL pulse only per REQ-022.

Verification
REQ-037 mode=0, dest=1, PC=16'h0150, memory[0150]=34, memory[0151]=12, mem_rdy=1 -> DE=16'h1234, PC=16'h0152, done at start+7.
REQ-038 mode=1, dest=2, SP=16'hFFFF, memory[FFFF]=CD, memory[0000]=AB -> HL=16'hABCD, SP=16'h0001 (wrap).
REQ-039 mode=1, dest=3, and separately dest=5 -> err pulses 1 cycle, busy stays 0, no regfile_we.
REQ-040 mem_rdy held low 5 cycles in RD_HI -> mem_re held high and mem_addr stable throughout; done at start+12.
REQ-041 reset asserted in WR_HI -> next cycle state IDLE, regfile_we=0, only the low byte of dest was written.
REQ-042 With LD16_TIMEOUT_EN, mem_rdy never asserted -> err on the 16th RD_LO cycle, no writes; without the macro, busy stays high.
